// File: rtl/dmem_req_ctrl.sv
// Pipeline-to-data-memory request controller: IDLE/ISSUE/WAIT/RESP handshake bridge.
// Optional alignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_req_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic            req_re,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_func3,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic            mem_re,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_func3,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_we;
  logic            r_re;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_func3;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_accept;
  logic            w_access;
  logic            w_trap;

  assign w_access = req_we | req_re;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_misaligned;

  always_comb begin
    case (req_func3[1:0])
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      default: w_misaligned = |req_addr[2:0];
    endcase
  end

  // Only real accesses can trap; a no-op never reports an error.
  assign w_trap = w_access & w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_access && !w_trap) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        mem_we      = r_we;
        mem_re      = r_re;
        w_state_nxt = r_re ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        mem_re      = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store wins when both we and re are set, so r_re is cleared for that case.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_func3 <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we & ~w_trap;
      r_re    <= req_re & ~req_we & ~w_trap;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_func3 <= req_func3;
      r_rdata <= '0;
      r_err   <= w_trap;
    end else if (r_state == S_WAIT) begin
      r_rdata <= mem_rdata;
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_func3  = r_func3;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed self-checking bench for dmem_req_ctrl with a byte-addressed data memory model.
module tb_dmem_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_re;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [2:0]  req_func3;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [63:0] mem_rdata;

  int n_checks;
  int n_fail;

  logic [7:0] mem [0:255];

  dmem_req_ctrl #(.XLEN(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_re     (req_re),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_func3  (req_func3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_func3  (mem_func3),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mem_load(input logic [7:0] a, input logic [2:0] f3);
    logic [63:0] v;
    int unsigned n;
    v = '0;
    n = 1 << f3[1:0];
    for (int unsigned i = 0; i < 8; i++)
      if (i < n) v[i*8 +: 8] = mem[8'(a + 8'(i))];
    if (!f3[2]) begin
      case (f3[1:0])
        2'b00:   v = {{56{v[7]}}, v[7:0]};
        2'b01:   v = {{48{v[15]}}, v[15:0]};
        2'b10:   v = {{32{v[31]}}, v[31:0]};
        default: v = v;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      for (int unsigned i = 0; i < 8; i++)
        if (i < (32'd1 << mem_func3[1:0]))
          mem[8'(mem_addr[7:0] + 8'(i))] <= mem_wdata[i*8 +: 8];
    end
    if (mem_re === 1'b1) mem_rdata <= mem_load(mem_addr[7:0], mem_func3);
  end

  // Called at #1 after an edge with the DUT idle; returns what was observed.
  task automatic do_req(input logic we, input logic re, input logic [63:0] a, input logic [63:0] d,
                        input logic [2:0] f3, output int lat, output logic [63:0] rd, output logic err,
                        output int nwe, output int wek, output int nre, output int abad);
    req_valid = 1'b1; req_we = we; req_re = re; req_addr = a; req_wdata = d; req_func3 = f3;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0;
    lat = 0; nwe = 0; wek = 0; nre = 0; abad = 0; rd = '0; err = 1'bx;
    for (int k = 0; k < 16; k++) begin
      if (mem_we === 1'b1) begin
        nwe++;
        if (wek == 0) wek = k + 1;
      end
      if (mem_re === 1'b1) begin
        nre++;
        if (mem_addr !== a || mem_func3 !== f3) abad++;
      end
      if (resp_valid === 1'b1) begin
        lat = k + 1; rd = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ctl: got we=%b re=%b expected 0 0", mem_we, mem_re); end
    n_checks++; if (resp_rdata !== 64'h0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %h/%b expected 0/0", resp_rdata, resp_err); end
    n_checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_func3 !== 3'b000) begin n_fail++; $display("FAIL reset_fields: got addr=%h wdata=%h f3=%b expected 0", mem_addr, mem_wdata, mem_func3); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    int lat, nwe, wek, nre, abad;
    logic [63:0] rd;
    logic err;
    do_req(1'b1, 1'b0, 64'h10, 64'hDEADBEEF_CAFEF00D, 3'b011, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sd_latency: got %0d expected 2", lat); end
    n_checks++; if (nwe !== 1 || wek !== 1) begin n_fail++; $display("FAIL sd_we_pulse: got count=%0d edge=T+%0d expected 1 at T+1", nwe, wek); end
    n_checks++; if (nre !== 0) begin n_fail++; $display("FAIL sd_no_re: got %0d expected 0", nre); end
    n_checks++; if (err !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL sd_resp: got %h/%b expected 0/0", rd, err); end
    do_req(1'b0, 1'b1, 64'h10, 64'h0, 3'b011, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL ld_latency: got %0d expected 3", lat); end
    n_checks++; if (rd !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL ld_data: got %h expected deadbeefcafef00d", rd); end
    n_checks++; if (nre !== 2 || abad !== 0 || nwe !== 0) begin n_fail++; $display("FAIL ld_mem_ctl: got re=%0d bad=%0d we=%0d expected 2 0 0", nre, abad, nwe); end
  endtask

  task automatic test_byte_sign;
    int lat, nwe, wek, nre, abad;
    logic [63:0] rd;
    logic err;
    do_req(1'b1, 1'b0, 64'h18, 64'h12345678_9ABCDE80, 3'b000, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (nwe !== 1) begin n_fail++; $display("FAIL sb_we: got %0d expected 1", nwe); end
    do_req(1'b0, 1'b1, 64'h18, 64'h0, 3'b000, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", lat); end
    n_checks++; if (rd !== 64'hFFFFFFFF_FFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffffffffffff80", rd); end
    n_checks++; if (abad !== 0 || nre !== 2) begin n_fail++; $display("FAIL lb_addr_hold: got bad=%0d re=%0d expected 0 2", abad, nre); end
    do_req(1'b0, 1'b1, 64'h18, 64'h0, 3'b100, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (rd !== 64'h80) begin n_fail++; $display("FAIL lbu_data: got %h expected 80", rd); end
    do_req(1'b0, 1'b1, 64'h10, 64'h0, 3'b001, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (rd !== 64'hFFFFFFFF_FFFFF00D) begin n_fail++; $display("FAIL lh_data: got %h expected fffffffffffff00d", rd); end
    do_req(1'b0, 1'b1, 64'h14, 64'h0, 3'b110, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (rd !== 64'h00000000_DEADBEEF) begin n_fail++; $display("FAIL lwu_data: got %h expected 00000000deadbeef", rd); end
    do_req(1'b0, 1'b1, 64'h14, 64'h0, 3'b010, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (rd !== 64'hFFFFFFFF_DEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected ffffffffdeadbeef", rd); end
  endtask

  task automatic test_backpressure;
    int lat, nwe, wek, nre, abad;
    int k;
    logic [63:0] rd;
    logic err;
    req_valid = 1'b1; req_we = 1'b0; req_re = 1'b1; req_addr = 64'h10; req_wdata = '0; req_func3 = 3'b011;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    // A pending store stays on the request port the whole time.
    req_we = 1'b1; req_re = 1'b0; req_addr = 64'h40; req_wdata = 64'hAAAA_0055; req_func3 = 3'b000;
    k = 0;
    while (resp_valid !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++; if (k !== 2) begin n_fail++; $display("FAIL bp_latency: got T+%0d expected T+3", k + 1); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL bp_stable_%0d: got %b/%h expected 1/deadbeefcafef00d", i, resp_valid, resp_rdata); end
      n_checks++; if (req_ready !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL bp_blocked_%0d: got ready=%b we=%b expected 0 0", i, req_ready, mem_we); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got ready=%b valid=%b we=%b expected 1 0 0", req_ready, resp_valid, mem_we); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 64'h40) begin n_fail++; $display("FAIL bp_next_issue: got we=%b addr=%h expected 1 40", mem_we, mem_addr); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_req(1'b0, 1'b1, 64'h40, 64'h0, 3'b100, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (rd !== 64'h55) begin n_fail++; $display("FAIL bp_store_data: got %h expected 55", rd); end
  endtask

  task automatic test_misalign;
    int lat, nwe, wek, nre, abad;
    logic [63:0] rd;
    logic err;
    do_req(1'b1, 1'b0, 64'h20, 64'h01234567_89ABCDEF, 3'b011, lat, rd, err, nwe, wek, nre, abad);
    do_req(1'b0, 1'b1, 64'h22, 64'h0, 3'b010, lat, rd, err, nwe, wek, nre, abad);
`ifdef DMEM_MISALIGN_TRAP_EN
    n_checks++; if (lat !== 1 || err !== 1'b1) begin n_fail++; $display("FAIL lw_mis_trap: got lat=%0d err=%b expected 1 1", lat, err); end
    n_checks++; if (nre !== 0 || nwe !== 0 || rd !== 64'h0) begin n_fail++; $display("FAIL lw_mis_noaccess: got re=%0d we=%0d rd=%h expected 0 0 0", nre, nwe, rd); end
    do_req(1'b1, 1'b0, 64'h22, 64'hFFFF_FFFF, 3'b010, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (nwe !== 0 || err !== 1'b1) begin n_fail++; $display("FAIL sw_mis_trap: got we=%0d err=%b expected 0 1", nwe, err); end
`else
    n_checks++; if (lat !== 3 || err !== 1'b0) begin n_fail++; $display("FAIL lw_mis_pass: got lat=%0d err=%b expected 3 0", lat, err); end
    n_checks++; if (nre !== 2 || abad !== 0 || rd !== 64'h00000000_456789AB) begin n_fail++; $display("FAIL lw_mis_issue: got re=%0d bad=%0d rd=%h expected 2 0 00000000456789ab", nre, abad, rd); end
    do_req(1'b1, 1'b0, 64'h22, 64'hFFFF_FFFF, 3'b010, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (nwe !== 1 || err !== 1'b0) begin n_fail++; $display("FAIL sw_mis_pass: got we=%0d err=%b expected 1 0", nwe, err); end
`endif
  endtask

  task automatic test_noop;
    int lat, nwe, wek, nre, abad;
    logic [63:0] rd;
    logic err;
    do_req(1'b0, 1'b0, 64'h10, 64'h1234, 3'b011, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL noop_latency: got %0d expected 1", lat); end
    n_checks++; if (nwe !== 0 || nre !== 0 || rd !== 64'h0 || err !== 1'b0) begin n_fail++; $display("FAIL noop_resp: got we=%0d re=%0d rd=%h err=%b expected 0 0 0 0", nwe, nre, rd, err); end
  endtask

  task automatic test_we_re;
    int lat, nwe, wek, nre, abad;
    logic [63:0] rd;
    logic err;
    do_req(1'b1, 1'b1, 64'h08, 64'h11223344_55667788, 3'b011, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (nwe !== 1 || nre !== 0) begin n_fail++; $display("FAIL wr_as_store: got we=%0d re=%0d expected 1 0", nwe, nre); end
    n_checks++; if (lat !== 2 || rd !== 64'h0) begin n_fail++; $display("FAIL wr_resp: got lat=%0d rd=%h expected 2 0", lat, rd); end
    do_req(1'b0, 1'b1, 64'h08, 64'h0, 3'b011, lat, rd, err, nwe, wek, nre, abad);
    n_checks++; if (rd !== 64'h11223344_55667788) begin n_fail++; $display("FAIL wr_readback: got %h expected 1122334455667788", rd); end
  endtask

  task automatic test_reset_in_wait;
    req_valid = 1'b1; req_we = 1'b0; req_re = 1'b1; req_addr = 64'h10; req_func3 = 3'b011;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_re = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL rst_wait_entry: got re=%b expected 1", mem_re); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_state: got ready=%b valid=%b expected 1 0", req_ready, resp_valid); end
    n_checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || resp_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_wait_outs: got re=%b we=%b rd=%h expected 0 0 0", mem_re, mem_we, resp_rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_resp_lost: got valid=%b ready=%b expected 0 1", resp_valid, req_ready); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_re = 1'b0;
    req_addr = '0; req_wdata = '0; req_func3 = '0;
    resp_ready = 1'b1;
    test_reset;
    test_store_load;
    test_byte_sign;
    test_backpressure;
    test_misalign;
    test_noop;
    test_we_re;
    test_reset_in_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
